// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, stage status codes and the
// one-hot processor status reported by the pipeline control unit.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [2:0] CPU_AOK = 3'b001;
    localparam logic [2:0] CPU_ERR = 3'b010;
    localparam logic [2:0] CPU_HLT = 3'b100;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } cpu_state_e;

    function automatic logic [2:0] state_to_stat(input cpu_state_e s);
        case (s)
            ST_HALTED: return CPU_HLT;
            ST_FAULT:  return CPU_ERR;
            default:   return CPU_AOK;
        endcase
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Three independent saturating event counters (cycles, retires, stalls).
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cyc_en,
    input  logic             ret_en,
    input  logic             stall_en,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        cyc_d   = cyc_q;
        ret_d   = ret_q;
        stall_d = stall_q;
        if (cyc_en && cyc_q != CNT_MAX) begin
            cyc_d = cyc_q + 1'b1;
        end
        if (ret_en && ret_q != CNT_MAX) begin
            ret_d = ret_q + 1'b1;
        end
        if (stall_en && stall_q != CNT_MAX) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q   <= '0;
            ret_q   <= '0;
            stall_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            ret_q   <= ret_d;
            stall_q <= stall_d;
        end
    end

    assign cyc_cnt   = cyc_q;
    assign ret_cnt   = ret_q;
    assign stall_cnt = stall_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: per-cycle stall/bubble decisions from hazard
// inputs, the RUN/HALTED/FAULT status machine and performance counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [3:0] REG_NONE = 4'hF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [1:0]       W_stat,
    input  logic             W_valid,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [2:0]       cpu_stat,
    output logic             done,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    cpu_state_e state_q, state_d;
    logic [2:0] cpu_stat_q, cpu_stat_d;
    logic       done_q, done_d;

    logic load_use, ret_pend, mispred, exc_m, exc_w, run;

    assign load_use = (E_icode == I_MRMOVQ || E_icode == I_POPQ) &&
                      (E_dstM != REG_NONE) &&
                      (E_dstM == d_srcA || E_dstM == d_srcB);
    assign ret_pend = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mispred  = (E_icode == I_JXX) && !e_cnd;
    assign exc_m    = (m_stat != STAT_AOK);
    assign exc_w    = (W_stat != STAT_AOK);
    assign run      = (state_q == ST_RUN);

    // Once stopped the whole pipeline is frozen regardless of hazards.
    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b1;
        set_cc   = 1'b0;
        if (run) begin
            F_stall  = load_use | ret_pend;
            D_stall  = load_use;
            D_bubble = mispred | (!load_use & ret_pend);
            E_bubble = mispred | load_use;
            M_bubble = exc_m | exc_w;
            W_stall  = exc_w;
            set_cc   = (E_icode == I_OPQ) & !exc_m & !exc_w;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (W_valid && W_stat == STAT_HLT) begin
                    state_d = ST_HALTED;
                    done_d  = 1'b1;
                end else if (W_valid && (W_stat == STAT_ADR || W_stat == STAT_INS)) begin
                    state_d = ST_FAULT;
                    done_d  = 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
        cpu_stat_d = state_to_stat(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            cpu_stat_q <= CPU_AOK;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_stat_q <= cpu_stat_d;
            done_q     <= done_d;
        end
    end

    assign cpu_stat = cpu_stat_q;
    assign done     = done_q;

    pipe_perf_cnt #(
        .CNT_W(CNT_W)
    ) u_perf_cnt (
        .clk      (clk),
        .rst      (rst),
        .cyc_en   (run),
        .ret_en   (run && W_valid && W_stat == STAT_AOK && !W_stall),
        .stall_en (run && F_stall),
        .cyc_cnt  (cyc_cnt),
        .ret_cnt  (ret_cnt),
        .stall_cnt(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a behavioural model
// of the hazard rules, status machine and saturating counters.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic        e_cnd;
    logic [1:0]  m_stat, W_stat;
    logic        W_valid;

    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, done;
    logic [2:0]  cpu_stat;
    logic [31:0] cyc_cnt, ret_cnt, stall_cnt;

    logic        F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc4, done4;
    logic [2:0]  cpu_stat4;
    logic [3:0]  cyc_cnt4, ret_cnt4, stall_cnt4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 = RUN, 1 = HALTED, 2 = FAULT
    int     m_state;
    bit     m_done;
    longint m_cyc, m_ret, m_stall;
    longint m_cyc4, m_ret4, m_stall4;

    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX4  = 64'd15;

    pipe_ctrl #(.CNT_W(32), .REG_NONE(4'hF)) u_dut (
        .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .W_valid(W_valid),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc), .cpu_stat(cpu_stat),
        .done(done), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.CNT_W(4), .REG_NONE(4'hF)) u_dut4 (
        .clk(clk), .rst(rst), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd), .M_icode(M_icode),
        .m_stat(m_stat), .W_stat(W_stat), .W_valid(W_valid),
        .F_stall(F_stall4), .D_stall(D_stall4), .D_bubble(D_bubble4), .E_bubble(E_bubble4),
        .M_bubble(M_bubble4), .W_stall(W_stall4), .set_cc(set_cc4), .cpu_stat(cpu_stat4),
        .done(done4), .cyc_cnt(cyc_cnt4), .ret_cnt(ret_cnt4), .stall_cnt(stall_cnt4)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic longint sat_inc(input longint v, input longint mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // Expected {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    function automatic logic [6:0] ref_ctrl();
        bit lu, rp, mp, em, ew;
        if (m_state != 0) return 7'b1100010;
        lu = (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
             (E_dstM == d_srcA || E_dstM == d_srcB);
        rp = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
        mp = (E_icode == 4'h7) && !e_cnd;
        em = (m_stat != 2'd0);
        ew = (W_stat != 2'd0);
        return {lu | rp, lu, mp | (!lu & rp), mp | lu, em | ew, ew,
                (E_icode == 4'h6) && !em && !ew};
    endfunction

    function automatic logic [2:0] ref_stat();
        case (m_state)
            1:       return 3'b100;
            2:       return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [6:0] ctrl_bus();
        return {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
    endfunction

    // Driver: inputs are already set; check, clock, then advance the model.
    task automatic tick();
        logic [6:0] ec;
        #2;
        ec = ref_ctrl();
        check_eq("ctrl", ctrl_bus(), ec);
        check_eq("ctrl4", {F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, set_cc4}, ec);
        check_eq("cpu_stat", cpu_stat, ref_stat());
        check_eq("cpu_stat4", cpu_stat4, ref_stat());
        check_eq("done", done, m_done);
        check_eq("done4", done4, m_done);
        check_eq("cyc_cnt", cyc_cnt, m_cyc);
        check_eq("ret_cnt", ret_cnt, m_ret);
        check_eq("stall_cnt", stall_cnt, m_stall);
        check_eq("cyc_cnt4", cyc_cnt4, m_cyc4);
        check_eq("ret_cnt4", ret_cnt4, m_ret4);
        check_eq("stall_cnt4", stall_cnt4, m_stall4);
        @(posedge clk);
        if (rst) begin
            m_state = 0; m_done = 0;
            m_cyc = 0; m_ret = 0; m_stall = 0;
            m_cyc4 = 0; m_ret4 = 0; m_stall4 = 0;
        end else begin
            m_done = 0;
            if (m_state == 0) begin
                m_cyc  = sat_inc(m_cyc, MAX32);
                m_cyc4 = sat_inc(m_cyc4, MAX4);
                if (W_valid && W_stat == 2'd0 && !ec[1]) begin
                    m_ret  = sat_inc(m_ret, MAX32);
                    m_ret4 = sat_inc(m_ret4, MAX4);
                end
                if (ec[6]) begin
                    m_stall  = sat_inc(m_stall, MAX32);
                    m_stall4 = sat_inc(m_stall4, MAX4);
                end
                if (W_valid && W_stat == 2'd1) begin
                    m_state = 1; m_done = 1;
                end else if (W_valid && W_stat >= 2'd2) begin
                    m_state = 2; m_done = 1;
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        E_icode = 4'h1; E_dstM = 4'hF; e_cnd = 0; M_icode = 4'h1;
        m_stat = 0; W_stat = 0; W_valid = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic expect_ctrl(input string tag, input logic [6:0] exp);
        #1;
        check_eq(tag, ctrl_bus(), exp);
    endtask

    task automatic rand_inputs();
        int r;
        D_icode = 4'($urandom_range(0, 11));
        E_icode = 4'($urandom_range(0, 11));
        M_icode = 4'($urandom_range(0, 11));
        d_srcA  = 4'($urandom_range(0, 15));
        d_srcB  = 4'($urandom_range(0, 15));
        E_dstM  = ($urandom_range(0, 2) == 0) ? d_srcA : 4'($urandom_range(0, 15));
        e_cnd   = 1'($urandom_range(0, 1));
        m_stat  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        W_valid = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 99);
        W_stat  = (r < 3) ? 2'd1 : (r < 6) ? 2'($urandom_range(2, 3)) : 2'd0;
        rst     = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        m_state = 0; m_done = 0;
        m_cyc = 0; m_ret = 0; m_stall = 0;
        m_cyc4 = 0; m_ret4 = 0; m_stall4 = 0;
        idle();
        rst = 1;
        @(posedge clk);
        #1;

        // Reset state
        do_reset();
        check_eq("rst_stat", cpu_stat, 3'b001);
        check_eq("rst_cyc", cyc_cnt, 32'd0);

        // Load-use
        idle(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
        expect_ctrl("load_use", 7'b1101000);
        tick();

        // Ret in decode, alone then with load-use
        for (int i = 0; i < 3; i++) begin
            idle(); D_icode = 4'h9;
            expect_ctrl("ret", 7'b1010000);
            tick();
        end
        idle(); D_icode = 4'h9; E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
        expect_ctrl("ret_lu", 7'b1101000);
        tick();

        // Mispredict / taken jump
        idle(); E_icode = 4'h7; e_cnd = 0;
        expect_ctrl("mispred", 7'b0011000);
        tick();
        idle(); E_icode = 4'h7; e_cnd = 1;
        expect_ctrl("jmp_taken", 7'b0000000);
        tick();

        // Memory fault flowing into write-back
        idle(); m_stat = 2'd2; E_icode = 4'h6;
        expect_ctrl("mem_exc", 7'b0000100);
        tick();
        idle(); W_valid = 1; W_stat = 2'd2;
        expect_ctrl("wb_exc", 7'b0000110);
        tick();
        idle();
        expect_ctrl("frozen", 7'b1100010);
        check_eq("fault_stat", cpu_stat, 3'b010);
        check_eq("fault_done", done, 1'b1);
        tick();
        check_eq("fault_done_once", done, 1'b0);
        tick();

        // Halt after ten retired instructions, then reset from HALTED
        do_reset();
        for (int i = 0; i < 10; i++) begin
            idle(); W_valid = 1;
            tick();
        end
        idle(); W_valid = 1; W_stat = 2'd1;
        tick();
        idle();
        tick();
        tick();
        check_eq("halt_stat", cpu_stat, 3'b100);
        check_eq("halt_ret", ret_cnt, 32'd10);
        check_eq("halt_cyc", cyc_cnt, 32'd11);
        do_reset();
        check_eq("rerun_stat", cpu_stat, 3'b001);
        check_eq("rerun_ret", ret_cnt, 32'd0);

        // Saturation of the narrow counters
        for (int i = 0; i < 20; i++) begin
            idle();
            tick();
        end
        check_eq("sat_cyc4", cyc_cnt4, 4'd15);
        check_eq("sat_cyc32", cyc_cnt, 32'd20);

        // Random episodes, each ending a few cycles after the CPU stops
        for (int ep = 0; ep < 12; ep++) begin
            int post;
            do_reset();
            post = 0;
            for (int c = 0; c < 120 && post < 4; c++) begin
                rand_inputs();
                tick();
                if (m_state != 0) post++;
            end
        end

        idle();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline control unit for the five-stage Y86-64 pipeline (fetch, decode, execute, memory, write-back).
- Each cycle, decides stall/bubble for every pipeline register from hazard inputs: load-use, ret, mispredicted jump, and exceptions in the memory or write-back stage.
- Owns the processor status FSM (RUN / HALTED / FAULT) and the retire/cycle/stall counters, replacing the ad-hoc stat/$finish logic at top level.

Parameters:
- CNT_W, 32, width of the cycle, retire and stall counters (saturating).
- REG_NONE, 4'hF, register ID meaning "no register".

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- D_icode  in  4  icode in the decode pipeline register.
- d_srcA  in  4  decode source register A.
- d_srcB  in  4  decode source register B.
- E_icode  in  4  icode in the execute register.
- E_dstM  in  4  execute-stage memory destination register.
- e_cnd  in  1  branch condition computed in execute.
- M_icode  in  4  icode in the memory register.
- m_stat  in  2  status produced by the memory stage.
- W_stat  in  2  status in the write-back register.
- W_valid  in  1  write-back register holds a real (non-bubble) instruction.
- F_stall  out  1  hold the fetch PC register.
- D_stall  out  1  hold the decode register.
- D_bubble  out  1  load a nop into the decode register.
- E_bubble  out  1  load a nop into the execute register.
- M_bubble  out  1  load a nop into the memory register.
- W_stall  out  1  hold the write-back register.
- set_cc  out  1  condition codes may update this cycle.
- cpu_stat  out  3  one-hot: [0] AOK, [1] error (ADR or INS), [2] HLT.
- done  out  1  one-cycle pulse on entry to HALTED or FAULT.
- cyc_cnt  out  CNT_W  cycles spent in RUN.
- ret_cnt  out  CNT_W  instructions retired.
- stall_cnt  out  CNT_W  cycles with F_stall=1.

Behaviour:
- Stage status encoding: AOK=0, HLT=1, ADR=2, INS=3.
- Control outputs are combinational, evaluated in the same cycle as their inputs.
- Hazard terms:
  - load_use = E_icode in {MRMOVQ, POPQ} and E_dstM != REG_NONE and E_dstM in {d_srcA, d_srcB}.
  - ret_pend = RET in {D_icode, E_icode, M_icode}.
  - mispred = E_icode==JXX and !e_cnd.
  - exc_m = m_stat != AOK.
  - exc_w = W_stat != AOK.
- Output equations:
  - F_stall = load_use | ret_pend.
  - D_stall = load_use.
  - D_bubble = mispred | (!load_use & ret_pend).
  - E_bubble = mispred | load_use.
  - M_bubble = exc_m | exc_w.
  - W_stall = exc_w.
  - set_cc = E_icode==OPQ & !exc_m & !exc_w.
- Priority: load_use with a simultaneous ret in decode gives stall, not bubble, for D. Mispredict and load_use together give E_bubble=1, D_bubble=1, D_stall=1; the pipeline registers treat bubble as dominant over stall.
- In HALTED or FAULT, all stall outputs are forced to 1, all bubble outputs to 0, and set_cc to 0 (pipeline frozen).
- FSM, one transition per rising clk:
  - RUN -> HALTED when W_valid & W_stat==HLT.
  - RUN -> FAULT when W_valid & W_stat in {ADR, INS}.
  - HALTED and FAULT are terminal until rst.
- cpu_stat: RUN=001, FAULT=010, HALTED=100. It changes the cycle after the terminating instruction reaches W.
- done is high for exactly the first cycle in HALTED/FAULT.
- Counters (saturate at all-ones; no wrap):
  - cyc_cnt increments every RUN cycle.
  - ret_cnt increments when W_valid & W_stat==AOK & !W_stall in RUN.
  - stall_cnt increments when F_stall=1 in RUN.
- Reset: the state register goes to RUN, all counters to 0, done to 0, so cpu_stat=001. Combinational outputs follow their inputs immediately after reset. Reset mid-operation, including while HALTED, returns to RUN the next cycle.

Decomposition:
- Package y86_pkg holds:
  - icode constants (HALT=0, NOP=1, CMOV=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=A, POPQ=B);
  - stage-status codes;
  - cpu_stat one-hot constants;
  - REG_NONE.
- Sub-module pipe_perf_cnt (three saturating counters with enables) is separated out.
- Hazard equations and FSM stay in pipe_ctrl.

Test Plan:
- Load-use: E_icode=5, E_dstM=3, d_srcA=3 -> F_stall=1, D_stall=1, E_bubble=1, D_bubble=0; stall_cnt +1.
- Ret: D_icode=9 with no load_use for 3 cycles -> F_stall=1, D_bubble=1 each cycle; same with load_use also true -> D_stall=1, D_bubble=0.
- Mispredict: E_icode=7, e_cnd=0 -> D_bubble=1, E_bubble=1, F_stall=0; with e_cnd=1 all control outputs are 0.
- Memory fault: m_stat=2, E_icode=6 -> M_bubble=1, set_cc=0. Next cycle W_valid=1, W_stat=2 -> W_stall=1. Following cycle cpu_stat=010, done pulses once, then all stalls=1 thereafter.
- Halt: W_valid=1, W_stat=1 after 10 retired AOK instructions -> cpu_stat=100, ret_cnt=10, cyc_cnt frozen; rst=1 for one cycle -> cpu_stat=001, counters=0.
- Saturation: CNT_W=4 run 20 cycles -> cyc_cnt holds at 15.
